// File: rtl/atm_txn_logger_if.sv
// Read-side record channel of the ATM transaction logger.
// The logger drives the head record and rd_valid; the receipt/audit consumer
// answers with rd_ready.
interface atm_txn_logger_if #(
  parameter int card_width    = 3,
  parameter int balance_width = 20,
  parameter int seq_width     = 8
);
  logic                     rd_valid;
  logic                     rd_ready;
  logic [seq_width-1:0]     rd_seq;
  logic [card_width-1:0]    rd_card;
  logic [1:0]               rd_op;
  logic [balance_width-1:0] rd_balance;
  logic                     rd_error;

  modport master (
    output rd_valid, rd_seq, rd_card, rd_op, rd_balance, rd_error,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_seq, rd_card, rd_op, rd_balance, rd_error,
    output rd_ready
  );
endinterface

// File: rtl/atm_txn_logger.sv
// Transaction log buffer behind the ATM top level.
// One record per rising edge of op_done is pushed into a show-ahead FIFO
// that is drained over a valid/ready channel. A sticky overflow flag records
// dropped records, and a saturating per-session count is cleared on card eject.
module atm_txn_logger #(
  parameter int card_width    = 3,
  parameter int balance_width = 20,
  parameter int depth_log2    = 3,
  parameter int seq_width     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_done,
  input  logic                     error,
  input  logic                     card_out,
  input  logic [card_width-1:0]    card_number,
  input  logic [1:0]               operation,
  input  logic [balance_width-1:0] updated_balance,
  input  logic                     clr_overflow,
  atm_txn_logger_if.master         rd,
  output logic [depth_log2:0]      fill_level,
  output logic                     overflow,
  output logic [7:0]               session_txns
);

  localparam int depth     = 1 << depth_log2;
  localparam int rec_width = seq_width + card_width + 2 + balance_width + 1;

  logic [rec_width-1:0]  mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2-1:0] rd_ptr_next;
  logic [seq_width-1:0]  seq;
  logic                  op_done_q;
  logic                  card_out_q;

  logic                  push;
  logic                  card_edge;
  logic                  pop;
  logic                  full;
  logic                  write;
  logic                  drop;
  logic [depth_log2:0]   remaining;
  logic [depth_log2:0]   fill_next;
  logic [rec_width-1:0]  new_rec;
  logic [rec_width-1:0]  head_rec;

  // Event detection, FIFO admission and selection of the next head record.
  always_comb begin
    push        = op_done & ~op_done_q;
    card_edge   = card_out & ~card_out_q;
    pop         = rd.rd_valid & rd.rd_ready;
    full        = (fill_level == (depth_log2 + 1)'(depth));
    write       = push & (~full | pop);
    drop        = push & full & ~pop;
    remaining   = fill_level - (depth_log2 + 1)'(pop);
    fill_next   = remaining + (depth_log2 + 1)'(write);
    rd_ptr_next = rd_ptr + depth_log2'(pop);
    new_rec     = {seq, card_number, operation, updated_balance, error};
    head_rec    = mem[rd_ptr_next];
    if (remaining == '0) begin
      head_rec = new_rec;
    end
  end

  // Record storage; a write never targets the slot presented as the next head.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // FIFO pointers, show-ahead head registers, sequence and edge-detect state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      seq           <= '0;
      op_done_q     <= 1'b0;
      card_out_q    <= 1'b0;
      rd.rd_valid   <= 1'b0;
      rd.rd_seq     <= '0;
      rd.rd_card    <= '0;
      rd.rd_op      <= '0;
      rd.rd_balance <= '0;
      rd.rd_error   <= 1'b0;
    end else begin
      op_done_q   <= op_done;
      card_out_q  <= card_out;
      fill_level  <= fill_next;
      rd_ptr      <= rd_ptr_next;
      rd.rd_valid <= (fill_next != '0);
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push) begin
        seq <= seq + 1'b1;
      end
      if (fill_next != '0) begin
        {rd.rd_seq, rd.rd_card, rd.rd_op, rd.rd_balance, rd.rd_error} <= head_rec;
      end
    end
  end

  // Sticky overflow: a dropping push takes priority over a clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Per-session count of push events, saturating, restarted on card eject.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      session_txns <= '0;
    end else if (card_edge) begin
      session_txns <= push ? 8'd1 : 8'd0;
    end else if (push && session_txns != 8'hFF) begin
      session_txns <= session_txns + 8'd1;
    end
  end

endmodule

// File: tb/tb_atm_txn_logger.sv
// Self-checking bench for atm_txn_logger: directed scenarios plus a random
// phase, all compared against a queue-based model of the transaction log.
module tb_atm_txn_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_done;
  logic        error;
  logic        card_out;
  logic [2:0]  card_number;
  logic [1:0]  operation;
  logic [19:0] updated_balance;
  logic        clr_overflow;
  logic [3:0]  fill_level;
  logic        overflow;
  logic [7:0]  session_txns;

  atm_txn_logger_if #(.card_width(3), .balance_width(20), .seq_width(8)) rd_if ();

  atm_txn_logger #(
    .card_width(3), .balance_width(20), .depth_log2(3), .seq_width(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .op_done(op_done),
    .error(error),
    .card_out(card_out),
    .card_number(card_number),
    .operation(operation),
    .updated_balance(updated_balance),
    .clr_overflow(clr_overflow),
    .rd(rd_if),
    .fill_level(fill_level),
    .overflow(overflow),
    .session_txns(session_txns)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  seq;
    logic [2:0]  card;
    logic [1:0]  op;
    logic [19:0] bal;
    logic        err;
  } rec_t;

  rec_t model_q[$];
  rec_t last_head;
  int   m_seq;
  bit   m_ovf;
  int   m_session;
  bit   m_prev_op;
  bit   m_prev_card;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    last_head   = '0;
    m_seq       = 0;
    m_ovf       = 1'b0;
    m_session   = 0;
    m_prev_op   = 1'b0;
    m_prev_card = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic applyStimulus(input bit od, input bit er, input bit co,
                               input logic [2:0] cd, input logic [1:0] op,
                               input logic [19:0] bal, input bit rr, input bit clr);
    bit   push;
    bit   cedge;
    bit   pop;
    bit   was_full;
    bit   dropped;
    rec_t r;
    op_done         = od;
    error           = er;
    card_out        = co;
    card_number     = cd;
    operation       = op;
    updated_balance = bal;
    rd_if.rd_ready  = rr;
    clr_overflow    = clr;

    push        = od && !m_prev_op;
    cedge       = co && !m_prev_card;
    m_prev_op   = od;
    m_prev_card = co;
    pop         = rr && (model_q.size() > 0);
    was_full    = (model_q.size() == 8);
    dropped     = 1'b0;
    if (pop) void'(model_q.pop_front());
    if (push) begin
      if (!was_full || pop) begin
        r.seq  = 8'(m_seq);
        r.card = cd;
        r.op   = op;
        r.bal  = bal;
        r.err  = er;
        model_q.push_back(r);
      end else begin
        dropped = 1'b1;
      end
      m_seq = (m_seq + 1) % 256;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (cedge) m_session = push ? 1 : 0;
    else if (push && m_session < 255) m_session++;
    if (model_q.size() > 0) last_head = model_q[0];

    @(posedge clk);
    #1;
    checkOutput("rd_valid", rd_if.rd_valid, (model_q.size() > 0));
    checkOutput("fill_level", fill_level, model_q.size());
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("session_txns", session_txns, m_session);
    checkOutput("rd_seq", rd_if.rd_seq, last_head.seq);
    checkOutput("rd_card", rd_if.rd_card, last_head.card);
    checkOutput("rd_op", rd_if.rd_op, last_head.op);
    checkOutput("rd_balance", rd_if.rd_balance, last_head.bal);
    checkOutput("rd_error", rd_if.rd_error, last_head.err);
  endtask

  // A two-cycle op_done pulse carrying a random record.
  task automatic pushOnce(input bit rr);
    logic [2:0]  cd;
    logic [1:0]  op;
    logic [19:0] bal;
    bit          er;
    cd  = 3'($urandom);
    op  = 2'($urandom);
    bal = 20'($urandom);
    er  = 1'($urandom);
    applyStimulus(1'b1, er, 1'b0, cd, op, bal, rr, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, cd, op, bal, rr, 1'b0);
  endtask

  // Asynchronous reset pulse spanning one clock edge, checked while asserted.
  task automatic doReset();
    op_done        = 1'b0;
    card_out       = 1'b0;
    clr_overflow   = 1'b0;
    rd_if.rd_ready = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_fill", fill_level, 0);
    checkOutput("rst_valid", rd_if.rd_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_session", session_txns, 0);
    checkOutput("rst_rd_seq", rd_if.rd_seq, 0);
    checkOutput("rst_rd_balance", rd_if.rd_balance, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    rst             = 1'b0;
    op_done         = 1'b0;
    error           = 1'b0;
    card_out        = 1'b0;
    card_number     = '0;
    operation       = '0;
    updated_balance = '0;
    clr_overflow    = 1'b0;
    rd_if.rd_ready  = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    doReset();

    // Single op held high for five cycles yields exactly one record.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3'd3, 2'd2, 20'd1000, 0, 0);
    applyStimulus(0, 0, 0, 3'd3, 2'd2, 20'd1000, 0, 0);
    checkOutput("single_fill", fill_level, 1);
    checkOutput("single_seq", rd_if.rd_seq, 0);
    checkOutput("single_card", rd_if.rd_card, 3);
    checkOutput("single_op", rd_if.rd_op, 2);
    checkOutput("single_bal", rd_if.rd_balance, 1000);
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    checkOutput("single_drained", rd_if.rd_valid, 0);

    // Backpressure then drain in order.
    doReset();
    for (int i = 0; i < 4; i++) pushOnce(1'b0);
    checkOutput("bp_hold_seq", rd_if.rd_seq, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    checkOutput("bp_last_seq", rd_if.rd_seq, 3);
    checkOutput("bp_empty", rd_if.rd_valid, 0);

    // Overflow: nine pushes into depth eight.
    doReset();
    for (int i = 0; i < 9; i++) pushOnce(1'b0);
    checkOutput("ovf_fill", fill_level, 8);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_head", rd_if.rd_seq, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    pushOnce(1'b0);
    checkOutput("ovf_gap_seq", rd_if.rd_seq, 9);
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 0, 1);
    checkOutput("ovf_cleared", overflow, 0);

    // Fill again, then a dropping push coincident with a clear: set wins.
    for (int i = 0; i < 7; i++) pushOnce(1'b0);
    applyStimulus(1, 0, 0, 3'd5, 2'd1, 20'd77, 0, 1);
    checkOutput("ovf_set_wins", overflow, 1);
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 0, 1);

    // Full with simultaneous push and pop.
    applyStimulus(1, 1, 0, 3'd6, 2'd3, 20'd4242, 1, 0);
    checkOutput("full_pp_fill", fill_level, 8);
    checkOutput("full_pp_ovf", overflow, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    checkOutput("full_pp_new_bal", rd_if.rd_balance, 4242);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);

    // Session counting, eject, coincident eject and saturation.
    doReset();
    pushOnce(1'b1);
    pushOnce(1'b1);
    checkOutput("sess_two", session_txns, 2);
    applyStimulus(0, 0, 1, 3'd0, 2'd0, 20'd0, 1, 0);
    checkOutput("sess_eject", session_txns, 0);
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    applyStimulus(1, 0, 1, 3'd1, 2'd1, 20'd5, 1, 0);
    checkOutput("sess_coincident", session_txns, 1);
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 1, 0);
    for (int i = 0; i < 300; i++) pushOnce(1'b1);
    checkOutput("sess_saturate", session_txns, 255);

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
                    3'($urandom), 2'($urandom), 20'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(0, 0, 0, 3'd0, 2'd0, 20'd0, 0, 0);

    // Reset mid-stream with records stored.
    doReset();
    for (int i = 0; i < 3; i++) pushOnce(1'b0);
    checkOutput("mid_fill", fill_level, 3);
    doReset();
    pushOnce(1'b0);
    checkOutput("mid_seq_restart", rd_if.rd_seq, 0);
    checkOutput("mid_fill_one", fill_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
